// File: rtl/RSA_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | RSA_pkg : shared RSA job/result types and the job-arbiter states    |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
package RSA_pkg;

  localparam int KEY_W = 32;

  typedef logic [KEY_W-1:0] KeyType;

  typedef struct packed {
    KeyType msg;
    KeyType key;
    KeyType modulus;
  } RSAModIn;

  typedef struct packed {
    KeyType result;
  } RSAModOut;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rsa_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rsa_rr_pick : combinational round-robin pick starting after         |
// |               last_grant, wrapping modulo NUM_REQ                   |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
module rsa_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest offset to the nearest so the nearest valid wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (req[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rsa_job_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rsa_job_arbiter : round-robin sharing of one RSA core among          |
// |                   NUM_REQ requesters, one job in flight              |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
module rsa_job_arbiter
  import RSA_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_i_valid,
  output logic [NUM_REQ-1:0]     req_i_ready,
  input  RSAModIn [NUM_REQ-1:0]  req_i_in,
  output logic [NUM_REQ-1:0]     req_o_valid,
  input  logic [NUM_REQ-1:0]     req_o_ready,
  output RSAModOut               req_o_out,
  output logic                   core_i_valid,
  input  logic                   core_i_ready,
  output RSAModIn                core_i_in,
  input  logic                   core_o_valid,
  output logic                   core_o_ready,
  input  RSAModOut               core_o_out,
  output logic                   o_busy,
  output logic [ID_W-1:0]        o_owner
);

  arb_state_e      state_q, state_d;
  RSAModIn         job_q, job_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] winner;
  logic            any_valid;

  rsa_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req        (req_i_valid),
    .last_grant (last_grant_q),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      job_q        <= '0;
      owner_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      job_q        <= job_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    job_d        = job_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    req_i_ready  = '0;
    req_o_valid  = '0;
    core_o_ready = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (any_valid) begin
          // Ready is combinational, so it must be masked while reset is held.
          req_i_ready[winner] = rst;
          job_d               = req_i_in[winner];
          owner_d             = winner;
          state_d             = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (core_i_ready) begin
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        req_o_valid[owner_q] = core_o_valid;
        core_o_ready         = req_o_ready[owner_q];
        if (core_o_valid && req_o_ready[owner_q]) begin
          last_grant_d = owner_q;
          state_d      = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign core_i_valid = (state_q == ARB_ISSUE);
  assign core_i_in    = job_q;
  assign req_o_out    = core_o_out;
  assign o_busy       = (state_q != ARB_IDLE);
  assign o_owner      = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_rsa_job_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rsa_job_arbiter : randomized bench with a behavioural RSA core   |
// |                      stub and a round-robin reference model         |
// +--------------------------------------------------------------------+
module tb_rsa_job_arbiter;
  import RSA_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req_i_valid = '0;
  logic [N-1:0]     req_i_ready;
  RSAModIn [N-1:0]  req_i_in = '0;
  logic [N-1:0]     req_o_valid;
  logic [N-1:0]     req_o_ready = '0;
  RSAModOut         req_o_out;
  logic             core_i_valid;
  logic             core_i_ready = 1'b0;
  RSAModIn          core_i_in;
  logic             core_o_valid = 1'b0;
  logic             core_o_ready;
  RSAModOut         core_o_out = '0;
  logic             o_busy;
  logic [IDW-1:0]   o_owner;

  rsa_job_arbiter #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i_valid  (req_i_valid),
    .req_i_ready  (req_i_ready),
    .req_i_in     (req_i_in),
    .req_o_valid  (req_o_valid),
    .req_o_ready  (req_o_ready),
    .req_o_out    (req_o_out),
    .core_i_valid (core_i_valid),
    .core_i_ready (core_i_ready),
    .core_i_in    (core_i_in),
    .core_o_valid (core_o_valid),
    .core_o_ready (core_o_ready),
    .core_o_out   (core_o_out),
    .o_busy       (o_busy),
    .o_owner      (o_owner)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: one job owned at a time, round robin after last owner.
  bit      m_busy, m_issued;
  int      m_owner, m_last;
  RSAModIn m_job;

  // Core stub: computes the modular exponentiation after stub_lat cycles.
  bit          stub_full;
  int          stub_cnt, stub_lat;
  logic [31:0] stub_res;

  int          grant_q[$];
  bit          res_seen, obs_handshake;
  int          res_owner;
  logic [31:0] res_data;
  logic [N-1:0] res_ov, obs_ready, obs_o_valid;
  logic        obs_core_o_ready, obs_core_i_valid, obs_busy;
  RSAModIn     obs_core_i_in;
  RSAModOut    obs_out;

  function automatic logic [31:0] modexp(RSAModIn j);
    longint b, e, m, r;
    m = longint'(j.modulus);
    if (m == 0) return 32'd0;
    r = 1 % m;
    b = longint'(j.msg) % m;
    e = longint'(j.key);
    while (e > 0) begin
      if ((e % 2) == 1) r = (r * b) % m;
      b = (b * b) % m;
      e = e / 2;
    end
    return 32'(r);
  endfunction

  function automatic int rr_model(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic RSAModIn mk_job(int msg, int key, int modulus);
    RSAModIn j;
    j.msg     = 32'(msg);
    j.key     = 32'(key);
    j.modulus = 32'(modulus);
    return j;
  endfunction

  task automatic model_reset();
    m_busy    = 1'b0;
    m_issued  = 1'b0;
    m_owner   = 0;
    m_last    = N - 1;
    m_job     = '0;
    stub_full = 1'b0;
    stub_cnt  = 0;
    stub_res  = '0;
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    req_i_valid  = '0;
    req_o_ready  = '0;
    core_i_ready = 1'b0;
    core_o_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock: inputs already set at the falling edge; check, then advance.
  task automatic cycle();
    int w;
    logic [N-1:0] exp_ready, exp_ov, acc;
    bit hs, fire_i, fire_o, exp_civ, exp_cor;
    RSAModIn cap;
    core_o_valid      = stub_full && (stub_cnt == 0);
    core_o_out.result = stub_res;
    #1;
    w = m_busy ? -1 : rr_model(req_i_valid, m_last);
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    tests++;
    if (req_i_ready !== exp_ready) begin
      fails++; $display("FAIL req_i_ready: got %b expected %b", req_i_ready, exp_ready);
    end
    exp_civ = m_busy && !m_issued;
    tests++;
    if (core_i_valid !== exp_civ) begin
      fails++; $display("FAIL core_i_valid: got %b expected %b", core_i_valid, exp_civ);
    end
    if (exp_civ) begin
      tests++;
      if (core_i_in !== m_job) begin
        fails++; $display("FAIL core_i_in: got %h expected %h", core_i_in, m_job);
      end
    end
    exp_ov = '0;
    if (m_busy && m_issued && core_o_valid) exp_ov[m_owner] = 1'b1;
    tests++;
    if (req_o_valid !== exp_ov) begin
      fails++; $display("FAIL req_o_valid: got %b expected %b", req_o_valid, exp_ov);
    end
    exp_cor = (m_busy && m_issued) ? req_o_ready[m_owner] : 1'b0;
    tests++;
    if (core_o_ready !== exp_cor) begin
      fails++; $display("FAIL core_o_ready: got %b expected %b", core_o_ready, exp_cor);
    end
    tests++;
    if (o_busy !== m_busy || o_owner !== IDW'(m_owner)) begin
      fails++;
      $display("FAIL busy_owner: got %b/%0d expected %b/%0d", o_busy, o_owner, m_busy, m_owner);
    end
    if (exp_ov != '0) begin
      tests++;
      if (req_o_out !== core_o_out) begin
        fails++; $display("FAIL req_o_out: got %h expected %h", req_o_out, core_o_out);
      end
    end
    obs_ready        = req_i_ready;
    obs_o_valid      = req_o_valid;
    obs_core_o_ready = core_o_ready;
    obs_core_i_valid = core_i_valid;
    obs_core_i_in    = core_i_in;
    obs_out          = req_o_out;
    obs_busy         = o_busy;
    hs     = m_busy && m_issued && core_o_valid && req_o_ready[m_owner];
    obs_handshake = hs;
    fire_i = core_i_valid && core_i_ready;
    fire_o = core_o_valid && core_o_ready;
    cap    = core_i_in;
    acc    = req_i_valid & req_i_ready;
    for (int i = 0; i < N; i++) if (acc[i]) grant_q.push_back(i);
    if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1'b1; m_issued = 1'b0; m_owner = w; m_job = req_i_in[w];
      end
    end else if (!m_issued) begin
      if (core_i_ready) m_issued = 1'b1;
    end else if (hs) begin
      tests++;
      if (req_o_out.result !== modexp(m_job)) begin
        fails++;
        $display("FAIL result[%0d]: got %0d expected %0d", m_owner, req_o_out.result, modexp(m_job));
      end
      res_seen  = 1'b1;
      res_owner = m_owner;
      res_data  = req_o_out.result;
      res_ov    = req_o_valid;
      m_busy    = 1'b0;
      m_last    = m_owner;
    end
    @(posedge clk);
    #1;
    if (stub_full && stub_cnt > 0) stub_cnt--;
    if (fire_o) stub_full = 1'b0;
    if (fire_i) begin
      stub_full = 1'b1; stub_cnt = stub_lat; stub_res = modexp(cap);
    end
    req_i_valid = req_i_valid & ~acc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_i_valid = '1;
    #1;
    tests++;
    if (req_i_ready !== '0 || req_o_valid !== '0) begin
      fails++; $display("FAIL reset_ready_valid: got %b/%b expected 0/0", req_i_ready, req_o_valid);
    end
    tests++;
    if (core_i_valid !== 1'b0 || core_o_ready !== 1'b0) begin
      fails++; $display("FAIL reset_core: got %b/%b expected 0/0", core_i_valid, core_o_ready);
    end
    tests++;
    if (o_busy !== 1'b0 || o_owner !== '0) begin
      fails++; $display("FAIL reset_busy_owner: got %b/%0d expected 0/0", o_busy, o_owner);
    end
    do_reset();
  endtask

  task automatic test_single_job();
    int n;
    do_reset();
    req_o_ready  = '1;
    core_i_ready = 1'b1;
    stub_lat     = 3;
    res_seen     = 1'b0;
    req_i_in[2]  = mk_job(65, 17, 3233);
    req_i_valid  = 4'b0100;
    cycle();
    tests++;
    if (obs_ready !== 4'b0100) begin
      fails++; $display("FAIL single_ready: got %b expected 0100", obs_ready);
    end
    cycle();
    tests++;
    if (obs_core_i_valid !== 1'b1) begin
      fails++; $display("FAIL single_core_i_valid: got %b expected 1", obs_core_i_valid);
    end
    n = 0;
    while (!res_seen && n < 50) begin cycle(); n++; end
    tests++;
    if (!res_seen || res_owner != 2 || res_data !== 32'd2790 || res_ov !== 4'b0100) begin
      fails++;
      $display("FAIL single_result: got seen=%0d owner=%0d data=%0d valid=%b expected 1/2/2790/0100",
               res_seen, res_owner, res_data, res_ov);
    end
  endtask

  task automatic test_fairness();
    int n;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req_o_ready  = '1;
    core_i_ready = 1'b1;
    stub_lat     = 1;
    for (int i = 0; i < N; i++) req_i_in[i] = mk_job(i + 2, 17, 3233);
    grant_q.delete();
    n = 0;
    while (grant_q.size() < 5 && n < 300) begin
      req_i_valid = '1;
      cycle();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (i >= grant_q.size() || grant_q[i] != exp_order[i]) begin
        fails++;
        $display("FAIL fairness_grant[%0d]: got %0d expected %0d", i,
                 (i < grant_q.size()) ? grant_q[i] : -1, exp_order[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    RSAModOut out0;
    do_reset();
    core_i_ready = 1'b1;
    stub_lat     = 2;
    req_i_in[1]  = mk_job(7, 5, 221);
    req_i_valid  = 4'b0010;
    n = 0;
    cycle();
    while (!(m_issued && stub_full && stub_cnt == 0) && n < 50) begin cycle(); n++; end
    out0 = '0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i == 0) out0 = obs_out;
      tests++;
      if (obs_core_o_ready !== 1'b0 || obs_out !== out0 || obs_busy !== 1'b1 || obs_o_valid !== 4'b0010) begin
        fails++;
        $display("FAIL backpressure_hold: got rdy=%b out=%h busy=%b ov=%b expected 0/%h/1/0010",
                 obs_core_o_ready, obs_out, obs_busy, obs_o_valid, out0);
      end
    end
    req_o_ready[1] = 1'b1;
    cycle();
    tests++;
    if (obs_handshake !== 1'b1) begin
      fails++; $display("FAIL backpressure_release: got %b expected 1", obs_handshake);
    end
    cycle();
    tests++;
    if (obs_busy !== 1'b0) begin
      fails++; $display("FAIL backpressure_idle: got busy=%b expected 0", obs_busy);
    end
  endtask

  task automatic test_late_arrival();
    int n;
    do_reset();
    req_o_ready  = '1;
    core_i_ready = 1'b1;
    stub_lat     = 4;
    req_i_in[0]  = mk_job(11, 3, 187);
    req_i_valid  = 4'b0001;
    n = 0;
    while (!m_issued && n < 20) begin cycle(); n++; end
    req_i_in[3]    = mk_job(42, 7, 391);
    req_i_valid[3] = 1'b1;
    n = 0;
    obs_handshake = 1'b0;
    while (!obs_handshake && n < 50) begin
      cycle();
      n++;
      tests++;
      if (obs_ready[3] !== 1'b0) begin
        fails++; $display("FAIL late_ready_early: got %b expected 0", obs_ready[3]);
      end
    end
    cycle();
    tests++;
    if (obs_ready !== 4'b1000) begin
      fails++; $display("FAIL late_grant: got %b expected 1000", obs_ready);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    do_reset();
    req_o_ready  = '0;
    core_i_ready = 1'b1;
    stub_lat     = 0;
    for (int i = 0; i < N; i++) req_i_in[i] = mk_job(i + 20, 9, 899);
    req_i_valid = 4'b0100;
    n = 0;
    while (!m_issued && n < 20) begin cycle(); n++; end
    cycle();
    req_i_valid = '1;
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (req_i_ready !== '0 || req_o_valid !== '0 || core_i_valid !== 1'b0 ||
        core_o_ready !== 1'b0 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL midwait_reset: got ir=%b ov=%b civ=%b cor=%b busy=%b expected all 0",
               req_i_ready, req_o_valid, core_i_valid, core_o_ready, o_busy);
    end
    model_reset();
    core_o_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cycle();
    tests++;
    if (obs_ready !== 4'b0001) begin
      fails++; $display("FAIL midwait_first_grant: got %b expected 0001", obs_ready);
    end
  endtask

  task automatic test_issue_stall();
    int n;
    RSAModIn j;
    do_reset();
    req_o_ready  = '1;
    core_i_ready = 1'b0;
    stub_lat     = 1;
    j = mk_job(9, 13, 323);
    req_i_in[1] = j;
    req_i_valid = 4'b0010;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      tests++;
      if (obs_core_i_valid !== 1'b1 || obs_core_i_in !== j) begin
        fails++;
        $display("FAIL stall_hold: got %b/%h expected 1/%h", obs_core_i_valid, obs_core_i_in, j);
      end
    end
    core_i_ready = 1'b1;
    cycle();
    cycle();
    tests++;
    if (obs_core_i_valid !== 1'b0) begin
      fails++; $display("FAIL stall_accept_drop: got %b expected 0", obs_core_i_valid);
    end
    res_seen = 1'b0;
    n = 0;
    while (!res_seen && n < 20) begin cycle(); n++; end
    tests++;
    if (!res_seen || res_owner != 1) begin
      fails++; $display("FAIL stall_result: got seen=%0d owner=%0d expected 1/1", res_seen, res_owner);
    end
  endtask

  task automatic test_random();
    int jobs_done;
    do_reset();
    jobs_done = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_i_valid[i] && $urandom_range(0, 3) == 0) begin
          req_i_in[i] = mk_job($urandom_range(0, 5000), $urandom_range(1, 65535),
                               $urandom_range(2, 65535));
          req_i_valid[i] = 1'b1;
        end else if (req_i_valid[i] && $urandom_range(0, 39) == 0) begin
          req_i_valid[i] = 1'b0;
        end
      end
      core_i_ready = ($urandom_range(0, 2) != 0);
      req_o_ready  = N'($urandom);
      stub_lat     = $urandom_range(0, 4);
      res_seen     = 1'b0;
      cycle();
      if (res_seen) jobs_done++;
    end
    tests++;
    if (jobs_done < 10) begin
      fails++; $display("FAIL random_progress: got %0d jobs expected at least 10", jobs_done);
    end
  endtask

  initial begin
    model_reset();
    stub_lat = 1;
    test_reset();
    test_single_job();
    test_fairness();
    test_backpressure();
    test_late_arrival();
    test_reset_mid_wait();
    test_issue_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
